// File: rtl/veto_trigger_gate.sv
// Veto-gated trigger: opens a coincidence window on each fresh hit edge, fires a
// fixed-width pulse unless a masked veto is seen, then holds off for a dead time.
module veto_trigger_gate #(
  parameter int NCH       = 8,
  parameter int WIN_W     = 4,
  parameter int PULSE_LEN = 4,
  parameter int DEAD_LEN  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_dly,
  input  logic [NCH-1:0]   veto_in,
  input  logic [NCH-1:0]   veto_mask,
  input  logic [WIN_W-1:0] win_len,
  input  logic             cnt_clr,
  output logic             trig_out,
  output logic             veto_flag,
  output logic             busy,
  output logic [CNT_W-1:0] trig_cnt,
  output logic [CNT_W-1:0] veto_cnt
);

  localparam int PW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int DW  = (DEAD_LEN > 1) ? $clog2(DEAD_LEN) : 1;
  localparam int CW0 = (PW > DW) ? PW : DW;
  localparam int CW  = (CW0 > WIN_W) ? CW0 : WIN_W;

  localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] DEAD_RELOAD  = CW'(DEAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    FIRE   = 2'd2,
    DEAD   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc,
                                               input logic clr);
    if (clr)
      return '0;
    else if (inc && (v != {CNT_W{1'b1}}))
      return v + 1'b1;
    else
      return v;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vseen_q, vseen_d;
  logic             trig_q, trig_d;
  logic             flag_q, flag_d;
  logic             busy_q;
  logic             hit_prev_q;
  logic [NCH-1:0]   veto_s1_q, veto_s2_q;
  logic [CNT_W-1:0] trig_cnt_q, veto_cnt_q;
  logic             inc_trig, inc_veto;
  logic             hit_rise, vmask, v_now;

  // Stage 0: veto synchronizer and hit edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      veto_s1_q  <= '0;
      veto_s2_q  <= '0;
      hit_prev_q <= 1'b1;
    end else begin
      veto_s1_q  <= veto_in;
      veto_s2_q  <= veto_s1_q;
      hit_prev_q <= hit_dly;
    end
  end

  assign vmask    = |(veto_s2_q & veto_mask);
  assign hit_rise = hit_dly & ~hit_prev_q;
  assign v_now    = vseen_q | vmask;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vseen_d  = vseen_q;
    trig_d   = trig_q;
    flag_d   = 1'b0;
    inc_trig = 1'b0;
    inc_veto = 1'b0;
    case (state_q)
      IDLE: begin
        trig_d = 1'b0;
        if (hit_rise) begin
          cnt_d              = '0;
          cnt_d[WIN_W-1:0]   = win_len;
          vseen_d            = vmask;
          state_d            = WINDOW;
        end
      end
      WINDOW: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          vseen_d = v_now;
        end else if (v_now) begin
          flag_d   = 1'b1;
          inc_veto = 1'b1;
          cnt_d    = DEAD_RELOAD;
          state_d  = DEAD;
        end else begin
          trig_d   = 1'b1;
          inc_trig = 1'b1;
          cnt_d    = PULSE_RELOAD;
          state_d  = FIRE;
        end
      end
      FIRE: begin
        if (cnt_q == '0) begin
          trig_d  = 1'b0;
          cnt_d   = DEAD_RELOAD;
          state_d = DEAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q == '0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: begin
        trig_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Stage 1: FSM state, registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vseen_q    <= 1'b0;
      trig_q     <= 1'b0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      veto_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vseen_q    <= vseen_d;
      trig_q     <= trig_d;
      flag_q     <= flag_d;
      // Stays high one cycle past DEAD so the readout sees the full hold-off.
      busy_q     <= (state_d != IDLE) || (state_q != IDLE);
      trig_cnt_q <= sat_inc(trig_cnt_q, inc_trig, cnt_clr);
      veto_cnt_q <= sat_inc(veto_cnt_q, inc_veto, cnt_clr);
    end
  end

  assign trig_out  = trig_q;
  assign veto_flag = flag_q;
  assign busy      = busy_q;
  assign trig_cnt  = trig_cnt_q;
  assign veto_cnt  = veto_cnt_q;

endmodule

// File: tb/tb_veto_trigger_gate.sv
// Bench for veto_trigger_gate: directed scenarios plus random traffic, checked
// every cycle against a timeline model of window, pulse and dead-time intervals.
module tb_veto_trigger_gate;
  localparam int NCH  = 8;
  localparam int WW   = 4;
  localparam int P    = 4;
  localparam int D    = 16;
  localparam int CW   = 4;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, hit_dly, cnt_clr;
  logic [NCH-1:0] veto_in, veto_mask;
  logic [WW-1:0]  win_len;
  logic           trig_out, veto_flag, busy;
  logic [CW-1:0]  trig_cnt, veto_cnt;

  veto_trigger_gate #(.NCH(NCH), .WIN_W(WW), .PULSE_LEN(P), .DEAD_LEN(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hit_dly(hit_dly), .veto_in(veto_in), .veto_mask(veto_mask),
    .win_len(win_len), .cnt_clr(cnt_clr), .trig_out(trig_out), .veto_flag(veto_flag),
    .busy(busy), .trig_cnt(trig_cnt), .veto_cnt(veto_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  // Reference timeline: intervals in absolute cycle numbers
  logic [NCH-1:0] vin_hist [MAXC];
  logic           vm_hist  [MAXC];
  int   free_c, dec_c, win_t, fire_s, fire_e, flag_at, busy_from, busy_to;
  logic m_hprev;
  logic [CW-1:0] m_tcnt, m_vcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hprev = 1'b1;
    free_c = cyc + 1; dec_c = -1; win_t = 0;
    fire_s = 0; fire_e = -1; flag_at = -1; busy_from = 0; busy_to = -1;
    m_tcnt = '0; m_vcnt = '0;
    vin_hist[cyc] = '0;
    if (cyc >= 1) vin_hist[cyc-1] = '0;
  endtask

  task automatic step();
    logic v, vm, inc_t, inc_v;
    @(negedge clk);
    chk("trig_out",  32'(trig_out),  32'((cyc >= fire_s) && (cyc <= fire_e)));
    chk("veto_flag", 32'(veto_flag), 32'(cyc == flag_at));
    chk("busy",      32'(busy),      32'((cyc >= busy_from) && (cyc <= busy_to)));
    chk("trig_cnt",  32'(trig_cnt),  32'(m_tcnt));
    chk("veto_cnt",  32'(veto_cnt),  32'(m_vcnt));
    if (rst) begin
      model_reset();
    end else begin
      vin_hist[cyc] = veto_in;
      vm = (cyc >= 2) ? |(vin_hist[cyc-2] & veto_mask) : 1'b0;
      vm_hist[cyc] = vm;
      inc_t = 1'b0; inc_v = 1'b0;
      if (cyc == dec_c) begin
        v = 1'b0;
        for (int k = win_t; k <= cyc; k++) v |= vm_hist[k];
        if (!v) begin
          fire_s = cyc + 1; fire_e = cyc + P; free_c = cyc + 1 + P + D; inc_t = 1'b1;
        end else begin
          flag_at = cyc + 1; free_c = cyc + 1 + D; inc_v = 1'b1;
        end
        busy_to = free_c;
        dec_c = -1;
      end
      if (dec_c < 0 && cyc >= free_c && hit_dly && !m_hprev) begin
        win_t = cyc; dec_c = cyc + 1 + int'(win_len);
        busy_from = cyc + 1; busy_to = 1 << 30;
      end
      m_hprev = hit_dly;
      if (cnt_clr) begin
        m_tcnt = '0; m_vcnt = '0;
      end else begin
        if (inc_t && m_tcnt != '1) m_tcnt = m_tcnt + 1'b1;
        if (inc_v && m_vcnt != '1) m_vcnt = m_vcnt + 1'b1;
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drives a clean rising edge; the cycle with hit_dly=1 is T.
  task automatic hit_edge(input logic [WW-1:0] w);
    hit_dly = 1'b0; step();
    win_len = w; hit_dly = 1'b1; step();
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin vin_hist[i] = '0; vm_hist[i] = 1'b0; end
    rst = 1'b1; hit_dly = 1'b1; cnt_clr = 1'b0; veto_in = '0; veto_mask = '0; win_len = '0;
    repeat (2) @(posedge clk);
    #1; cyc = 0;
    model_reset();

    // Reset release with hit held high must not trigger
    step(); step();
    rst = 1'b0; run(6);
    chk("no_trig_after_reset", 32'(trig_cnt), 32'd0);
    hit_edge(4'd0); run(8);
    chk("first_trig_cnt", 32'(trig_cnt), 32'd1);
    hit_dly = 1'b0; run(20);

    // Masked veto seen at the last window sample -> vetoed
    veto_mask = 8'h01;
    hit_edge(4'd3); step();
    veto_in = 8'h01; step(); veto_in = '0; run(30);
    chk("veto_cnt_last_sample", 32'(veto_cnt), 32'd1);
    chk("trig_cnt_after_veto", 32'(trig_cnt), 32'd1);
    // Same veto one cycle later falls outside the window -> accepted
    hit_edge(4'd3); step(); step();
    veto_in = 8'h01; step(); veto_in = '0; run(30);
    chk("late_veto_accepted", 32'(trig_cnt), 32'd2);

    // Veto on a masked-off channel is ignored
    veto_mask = 8'hFE;
    hit_edge(4'd2); veto_in = 8'h01; step(); veto_in = '0; run(30);
    chk("masked_off_trig", 32'(trig_cnt), 32'd3);
    chk("masked_off_veto", 32'(veto_cnt), 32'd1);

    // Re-hits during FIRE/DEAD discarded; first accepted edge after busy
    veto_mask = '0;
    hit_edge(4'd0); step(); hit_dly = 1'b0; step();
    hit_dly = 1'b1; run(16);
    hit_dly = 1'b0; step(); hit_dly = 1'b1; step();
    hit_dly = 1'b0; step(); step();
    hit_dly = 1'b1; step(); step();
    chk("retrig_T25", 32'(trig_out), 32'd1);
    chk("retrig_cnt", 32'(trig_cnt), 32'd5);
    hit_dly = 1'b0; run(25);

    // Drive trig_cnt into saturation, then clear on an accept edge
    for (int n = 0; n < 13; n++) begin
      hit_edge(4'($urandom_range(0, 2))); hit_dly = 1'b0; run(24);
    end
    chk("trig_cnt_sat", 32'(trig_cnt), 32'hF);
    hit_edge(4'd0); cnt_clr = 1'b1; step(); cnt_clr = 1'b0; step();
    chk("clr_beats_inc", 32'(trig_cnt), 32'd0);
    hit_dly = 1'b0; run(25);

    // Reset during FIRE aborts immediately
    hit_edge(4'd0); step(); step();
    rst = 1'b1; step(); rst = 1'b0; hit_dly = 1'b0;
    chk("rst_trig_out", 32'(trig_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_veto_cnt", 32'(veto_cnt), 32'd0);
    run(5);

    // Random traffic
    veto_mask = 8'(($urandom));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) hit_dly = ~hit_dly;
      veto_in = 8'($urandom & $urandom & $urandom & $urandom);
      win_len = 4'($urandom_range(0, 6));
      cnt_clr = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      if (i % 300 == 299) veto_mask = ($urandom_range(0, 3) == 0) ? '0 : 8'($urandom);
      step();
    end
    rst = 1'b0; cnt_clr = 1'b0; run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/veto_trigger_gate.md
Name: veto_trigger_gate

Overview:
- Downstream consumer of the per-channel bit delay stage.
- Takes the delayed detector hit level (hit_dly) and opens a programmable coincidence window against NCH veto-paddle discriminator bits.
- Issues a fixed-width trigger pulse only if no masked veto fires inside the window, then enforces a dead time.
- Keeps saturating accepted-trigger and vetoed-event counters for slow-control readout.

Parameters:
NCH, 8, number of veto channels
WIN_W, 4, width of win_len (window length control)
PULSE_LEN, 4, trig_out high time in clk cycles (>=1)
DEAD_LEN, 16, dead-time cycles after each decision (>=1)
CNT_W, 16, width of trig_cnt / veto_cnt

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
hit_dly  in  1  delayed hit level from delay stage; already clk-synchronous
veto_in  in  NCH  raw veto discriminator bits; asynchronous
veto_mask  in  NCH  1 = channel participates in veto; quasi-static
win_len  in  WIN_W  extra window cycles; sampled at hit edge
cnt_clr  in  1  synchronous clear of both counters
trig_out  out  1  accepted-trigger pulse, PULSE_LEN cycles
veto_flag  out  1  one-cycle pulse when event is vetoed
busy  out  1  high whenever FSM not in IDLE
trig_cnt  out  CNT_W  accepted triggers, saturating
veto_cnt  out  CNT_W  vetoed events, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - trig_out=0, veto_flag=0, busy=0, trig_cnt=0, veto_cnt=0; state=IDLE.
  - Veto sync flops=0.
  - Hit-edge history register=1, so a hit_dly already high at reset release does not trigger.
  - rst mid-operation aborts any window/pulse/dead time immediately, with no counter increment.
- veto_in passes through a 2-flop synchronizer: veto_s lags veto_in by 2 clk cycles.
  - vmask = |(veto_s & veto_mask).
- hit_rise = hit_dly & ~hit_prev; hit_prev updates every cycle in all states.
- FSM states and transitions:
  - IDLE: on hit_rise at cycle T:
    - cnt<=win_len, vseen<=vmask, state<=WINDOW.
    - Otherwise stay in IDLE.
  - WINDOW, cnt!=0: cnt<=cnt-1, vseen<=vseen|vmask.
  - WINDOW, cnt==0 (cycle T+1+win_len): decide on v = vseen|vmask.
    - v=0 -> FIRE: trig_out<=1, trig_cnt increments.
    - v=1 -> DEAD: veto_flag<=1 for one cycle, veto_cnt increments.
  - FIRE: trig_out stays high for exactly PULSE_LEN cycles (T+2+win_len .. T+1+win_len+PULSE_LEN), then state<=DEAD.
  - DEAD: DEAD_LEN cycles, then state<=IDLE. hit_rise and veto ignored throughout.
- Window coverage: vmask sampled on cycles T..T+1+win_len inclusive (win_len+2 samples). win_len=0 is legal (2 samples).
- Decision latency: hit_rise at T -> trig_out or veto_flag first high at T+2+win_len.
- Retrigger: only a fresh rising edge rearms. A hit_dly held high through DEAD does not retrigger on return to IDLE. A hit that falls and rises during WINDOW/FIRE/DEAD is discarded.
- busy is registered: high from T+1 until the cycle after DEAD ends.
- Counters:
  - Saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over a same-cycle increment (result 0).
  - Counters are independent of the FSM state.
- veto_mask=0: all events accepted.

Test Plan:
1. Reset release with hit_dly=1 held -> no trig_out, busy=0; drop hit_dly, raise at T -> trig_out high T+2..T+5 (win_len=0, PULSE_LEN=4), trig_cnt=1.
2. win_len=3, mask=0x01, veto_in[0] pulsed 1 cycle so veto_s is high at T+4 -> veto_flag one cycle at T+5, trig_out stays 0, veto_cnt=1; same veto arriving at T+5 -> accepted.
3. Veto on a masked-off channel (mask=0xFE, veto_in[0]) during window -> trigger accepted, veto_cnt unchanged.
4. Second hit_rise at T+3 and at T+20 (DEAD_LEN=16, win_len=0, PULSE_LEN=4, busy through T+22) -> both ignored; hit_rise at T+23 -> new trigger at T+25.
5. Preload trig_cnt to 0xFFFF via repeated triggers -> stays 0xFFFF; cnt_clr coincident with an accept -> trig_cnt=0.
6. rst asserted during FIRE -> trig_out=0 next cycle, state IDLE, counters 0.
